// File: rtl/debug_cmd_rx.sv
// Host-to-FPGA debug command receiver: 8N1 deserializer, command parser and
// breakpoint comparator driving the CPU halt/step controls.
module debug_cmd_rx #(
   parameter int CLKS_PER_BIT = 217
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx,
   input  logic [15:0] addr,
   output logic        halt,
   output logic        step,
   output logic [15:0] bp_addr,
   output logic        bp_valid,
   output logic        cmd_err
);

   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

   localparam logic [7:0] CH_H  = 8'h48;
   localparam logic [7:0] CH_C  = 8'h43;
   localparam logic [7:0] CH_S  = 8'h53;
   localparam logic [7:0] CH_X  = 8'h58;
   localparam logic [7:0] CH_B  = 8'h42;
   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_SP = 8'h20;

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
   typedef enum logic [1:0] {P_CMD, P_HEX, P_TERM} p_state_t;

   logic        rx_meta_reg;
   logic        rxs_reg;
   logic        qual_reg;
   rx_state_t   rx_state_reg;
   logic [15:0] cnt_reg;
   logic [2:0]  idx_reg;
   logic [7:0]  data_reg;
   logic        byte_valid_reg;
   logic [7:0]  byte_reg;
   logic        frame_err_reg;

   p_state_t    p_state_reg;
   logic [1:0]  dcnt_reg;
   logic [15:0] shift_reg;
   logic        armed_reg;

   logic        is_hex;
   logic [3:0]  hex_val;
   logic        is_eol;
   logic        hit;

   // Sync flops reset low so a line that is still low after reset is never
   // mistaken for a start bit before it has been seen idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_reg    <= 1'b0;
         rxs_reg        <= 1'b0;
         qual_reg       <= 1'b0;
         rx_state_reg   <= R_IDLE;
         cnt_reg        <= '0;
         idx_reg        <= '0;
         data_reg       <= '0;
         byte_valid_reg <= 1'b0;
         byte_reg       <= '0;
         frame_err_reg  <= 1'b0;
      end else begin
         rx_meta_reg    <= rx;
         rxs_reg        <= rx_meta_reg;
         byte_valid_reg <= 1'b0;
         frame_err_reg  <= 1'b0;
         if (rxs_reg)
            qual_reg <= 1'b1;
         case (rx_state_reg)
            R_IDLE: begin
               if (!rxs_reg && qual_reg) begin
                  cnt_reg      <= '0;
                  rx_state_reg <= R_START;
               end
            end
            R_START: begin
               if (cnt_reg == HALF_LAST) begin
                  cnt_reg      <= '0;
                  idx_reg      <= '0;
                  rx_state_reg <= rxs_reg ? R_IDLE : R_DATA;
               end else begin
                  cnt_reg <= cnt_reg + 16'd1;
               end
            end
            R_DATA: begin
               if (cnt_reg == BIT_LAST) begin
                  cnt_reg           <= '0;
                  data_reg[idx_reg] <= rxs_reg;
                  idx_reg           <= idx_reg + 3'd1;
                  if (idx_reg == 3'd7)
                     rx_state_reg <= R_STOP;
               end else begin
                  cnt_reg <= cnt_reg + 16'd1;
               end
            end
            R_STOP: begin
               if (cnt_reg == BIT_LAST) begin
                  rx_state_reg <= R_IDLE;
                  if (rxs_reg) begin
                     byte_valid_reg <= 1'b1;
                     byte_reg       <= data_reg;
                  end else begin
                     frame_err_reg <= 1'b1;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 16'd1;
               end
            end
            default: rx_state_reg <= R_IDLE;
         endcase
      end
   end

   always_comb begin
      is_hex  = 1'b0;
      hex_val = 4'd0;
      if (byte_reg >= 8'h30 && byte_reg <= 8'h39) begin
         is_hex  = 1'b1;
         hex_val = byte_reg[3:0];
      end else if ((byte_reg >= 8'h41 && byte_reg <= 8'h46) ||
                   (byte_reg >= 8'h61 && byte_reg <= 8'h66)) begin
         is_hex  = 1'b1;
         hex_val = byte_reg[3:0] + 4'd9;
      end
   end

   assign is_eol = (byte_reg == CH_CR) || (byte_reg == CH_LF);
   assign hit    = bp_valid && armed_reg && (addr == bp_addr);

   // Later assignments win: a command in the same cycle overrides the
   // breakpoint hit and the re-arm.
   always_ff @(posedge clk) begin
      if (reset) begin
         p_state_reg <= P_CMD;
         dcnt_reg    <= '0;
         shift_reg   <= '0;
         armed_reg   <= 1'b1;
         halt        <= 1'b0;
         step        <= 1'b0;
         bp_addr     <= '0;
         bp_valid    <= 1'b0;
         cmd_err     <= 1'b0;
      end else begin
         step    <= 1'b0;
         cmd_err <= frame_err_reg;
         if (addr != bp_addr)
            armed_reg <= 1'b1;
         if (hit)
            halt <= 1'b1;
         if (byte_valid_reg) begin
            case (p_state_reg)
               P_CMD: begin
                  case (byte_reg)
                     CH_H: halt <= 1'b1;
                     CH_C: begin
                        halt      <= 1'b0;
                        armed_reg <= 1'b0;
                     end
                     CH_S: step <= halt;
                     CH_X: bp_valid <= 1'b0;
                     CH_B: begin
                        dcnt_reg    <= '0;
                        p_state_reg <= P_HEX;
                     end
                     CH_CR, CH_LF, CH_SP: ;
                     default: cmd_err <= 1'b1;
                  endcase
               end
               P_HEX: begin
                  if (is_hex) begin
                     shift_reg <= {shift_reg[11:0], hex_val};
                     dcnt_reg  <= dcnt_reg + 2'd1;
                     if (dcnt_reg == 2'd3)
                        p_state_reg <= P_TERM;
                  end else begin
                     cmd_err     <= 1'b1;
                     p_state_reg <= P_CMD;
                  end
               end
               P_TERM: begin
                  if (is_eol) begin
                     bp_addr   <= shift_reg;
                     bp_valid  <= 1'b1;
                     armed_reg <= 1'b1;
                  end else begin
                     cmd_err <= 1'b1;
                  end
                  p_state_reg <= P_CMD;
               end
               default: p_state_reg <= P_CMD;
            endcase
         end
      end
   end

endmodule
